// File: rtl/rs_station_param_pkg.sv
// Shared reservation-station types and constants: null tag, default widths,
// the entry record and the opcodes the ALU decodes.
package rs_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int OP_W_DEF   = 2;
  localparam int TAG_W_DEF  = 4;

  // Tag value meaning "operand already holds its value"; never names a producer.
  localparam int TAG_NONE = 0;

  localparam logic [OP_W_DEF-1:0] OP_ADD = 2'd0;
  localparam logic [OP_W_DEF-1:0] OP_SUB = 2'd1;
  localparam logic [OP_W_DEF-1:0] OP_AND = 2'd2;
  localparam logic [OP_W_DEF-1:0] OP_OR  = 2'd3;

  typedef struct packed {
    logic                  busy;
    logic [OP_W_DEF-1:0]   op;
    logic [TAG_W_DEF-1:0]  qj;
    logic [DATA_W_DEF-1:0] vj;
    logic [TAG_W_DEF-1:0]  qk;
    logic [DATA_W_DEF-1:0] vk;
  } rs_entry_t;

endpackage

// File: rtl/rs_station_param_age_matrix.sv
// Age matrix for the reservation station: tracks relative allocation order of
// busy entries and picks the oldest ready one as a one-hot vector.
module rs_age_matrix
  import rs_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             nRST,
  input  logic             flush,
  input  logic             alloc_en,
  input  logic [IDX_W-1:0] alloc_idx,
  input  logic [DEPTH-1:0] free,
  input  logic [DEPTH-1:0] ready,
  output logic [DEPTH-1:0] oldest
);

  // age[i][j] = 1 means entry i was allocated before entry j.
  logic [DEPTH-1:0] age [DEPTH];

  // A newly allocated entry is younger than every currently busy entry and
  // older than nothing; the row write comes last so the diagonal stays 0.
  always_ff @(posedge clk) begin
    if (!nRST || flush) begin
      for (int i = 0; i < DEPTH; i++) age[i] <= '0;
    end else if (alloc_en) begin
      for (int j = 0; j < DEPTH; j++) age[j][alloc_idx] <= !free[j];
      age[alloc_idx] <= '0;
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      oldest[i] = ready[i];
      for (int j = 0; j < DEPTH; j++) begin
        if (ready[j] && age[j][i]) oldest[i] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/rs_station_param.sv
// Parametrised Tomasulo reservation station: captures CDB results (with bypass at
// allocate) and dispatches the oldest ready entry over a valid/ready handshake.
module rs_station_param
  import rs_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int DATA_W   = 32,
  parameter int OP_W     = 2,
  parameter int TAG_W    = 4,
  parameter int TAG_BASE = 1
) (
  input  logic                       clk,
  input  logic                       nRST,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [OP_W-1:0]            in_op,
  input  logic [DATA_W-1:0]          in_vj,
  input  logic [DATA_W-1:0]          in_vk,
  input  logic [TAG_W-1:0]           in_qj,
  input  logic [TAG_W-1:0]           in_qk,
  output logic [TAG_W-1:0]           alloc_tag,
  input  logic                       cdb_valid,
  input  logic [TAG_W-1:0]           cdb_tag,
  input  logic [DATA_W-1:0]          cdb_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [OP_W-1:0]            out_op,
  output logic [DATA_W-1:0]          out_vj,
  output logic [DATA_W-1:0]          out_vk,
  output logic [TAG_W-1:0]           out_tag,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [TAG_W-1:0] NO_TAG = TAG_W'(TAG_NONE);

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [TAG_W-1:0]  qj;
    logic [DATA_W-1:0] vj;
    logic [TAG_W-1:0]  qk;
    logic [DATA_W-1:0] vk;
  } slot_t;

  slot_t            slots [DEPTH];
  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] ready;
  logic [DEPTH-1:0] oldest;
  logic [IDX_W-1:0] free_idx;
  logic             alloc;
  logic             dispatch;
  logic             cdb_hit;

  assign cdb_hit = cdb_valid && (cdb_tag != NO_TAG);

  // Lowest-index free slot wins the allocation.
  always_comb begin
    free_idx = '0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      if (!busy[i]) free_idx = IDX_W'(i);
    end
  end

  assign in_ready  = ~&busy;
  assign alloc     = in_valid && in_ready;
  assign alloc_tag = TAG_W'(TAG_BASE) + TAG_W'(free_idx);

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ready[i] = busy[i] && (slots[i].qj == NO_TAG) && (slots[i].qk == NO_TAG);
    end
  end

  rs_age_matrix #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_age (
    .clk       (clk),
    .nRST      (nRST),
    .flush     (flush),
    .alloc_en  (alloc),
    .alloc_idx (free_idx),
    .free      (~busy),
    .ready     (ready),
    .oldest    (oldest)
  );

  assign out_valid = |ready;
  assign dispatch  = out_valid && out_ready;

  always_comb begin
    out_op  = '0;
    out_vj  = '0;
    out_vk  = '0;
    out_tag = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (oldest[i]) begin
        out_op  = slots[i].op;
        out_vj  = slots[i].vj;
        out_vk  = slots[i].vk;
        out_tag = TAG_W'(TAG_BASE + i);
      end
    end
  end

  // Allocation always targets a free slot and dispatch a busy one, so they never collide.
  always_ff @(posedge clk) begin
    if (!nRST) begin
      busy  <= '0;
      count <= '0;
    end else if (flush) begin
      busy  <= '0;
      count <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (dispatch && oldest[i]) busy[i] <= 1'b0;
      end
      if (alloc) busy[free_idx] <= 1'b1;
      count <= count + CNT_W'(alloc) - CNT_W'(dispatch);
    end
  end

  // Payload storage; validity is carried entirely by busy, so it needs no reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (alloc && (free_idx == IDX_W'(i))) begin
        slots[i].op <= in_op;
        if (cdb_hit && (in_qj == cdb_tag)) begin
          slots[i].vj <= cdb_data;
          slots[i].qj <= NO_TAG;
        end else begin
          slots[i].vj <= in_vj;
          slots[i].qj <= in_qj;
        end
        if (cdb_hit && (in_qk == cdb_tag)) begin
          slots[i].vk <= cdb_data;
          slots[i].qk <= NO_TAG;
        end else begin
          slots[i].vk <= in_vk;
          slots[i].qk <= in_qk;
        end
      end else if (busy[i]) begin
        if (cdb_hit && (slots[i].qj == cdb_tag)) begin
          slots[i].vj <= cdb_data;
          slots[i].qj <= NO_TAG;
        end
        if (cdb_hit && (slots[i].qk == cdb_tag)) begin
          slots[i].vk <= cdb_data;
          slots[i].qk <= NO_TAG;
        end
      end
    end
  end

endmodule

// File: tb/tb_rs_station_param.sv
// Directed bench for rs_station_param (DEPTH=4, TAG_BASE=1): allocation order,
// CDB wakeup/bypass, oldest-first dispatch, slot reuse and flush.
module tb_rs_station_param;

  logic        clk = 1'b0;
  logic        nRST;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_op;
  logic [31:0] in_vj;
  logic [31:0] in_vk;
  logic [3:0]  in_qj;
  logic [3:0]  in_qk;
  logic [3:0]  alloc_tag;
  logic        cdb_valid;
  logic [3:0]  cdb_tag;
  logic [31:0] cdb_data;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_op;
  logic [31:0] out_vj;
  logic [31:0] out_vk;
  logic [3:0]  out_tag;
  logic [2:0]  count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rs_station_param #(.DEPTH(4), .DATA_W(32), .OP_W(2), .TAG_W(4), .TAG_BASE(1)) dut (
    .clk       (clk),
    .nRST      (nRST),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_vj     (in_vj),
    .in_vk     (in_vk),
    .in_qj     (in_qj),
    .in_qk     (in_qk),
    .alloc_tag (alloc_tag),
    .cdb_valid (cdb_valid),
    .cdb_tag   (cdb_tag),
    .cdb_data  (cdb_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_op    (out_op),
    .out_vj    (out_vj),
    .out_vk    (out_vk),
    .out_tag   (out_tag),
    .count     (count)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_op     = '0;
    in_vj     = '0;
    in_vk     = '0;
    in_qj     = '0;
    in_qk     = '0;
    cdb_valid = 1'b0;
    cdb_tag   = '0;
    cdb_data  = '0;
    out_ready = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    nRST = 1'b0;
    step();
    step();
    nRST = 1'b1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [31:0] vj, input logic [3:0] qj,
                       input logic [31:0] vk, input logic [3:0] qk);
    in_valid = 1'b1;
    in_op    = op;
    in_vj    = vj;
    in_qj    = qj;
    in_vk    = vk;
    in_qk    = qk;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_in_ready got=%0b exp=1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_out_valid got=%0b exp=0", out_valid); end
    total++; if (count !== 3'd0) begin bad++; $display("[TB] FAIL reset_count got=%0d exp=0", count); end
    total++; if (out_tag !== 4'd0) begin bad++; $display("[TB] FAIL reset_out_tag got=%0d exp=0", out_tag); end
    total++; if (out_vj !== 32'd0) begin bad++; $display("[TB] FAIL reset_out_vj got=%0h exp=0", out_vj); end
  endtask

  task automatic test_fill();
    do_reset();
    for (int k = 0; k < 4; k++) begin
      issue(2'(k), 32'h10 + k, 4'd0, 32'h20 + k, 4'd0);
      #1;
      total++; if (alloc_tag !== 4'(k + 1)) begin bad++; $display("[TB] FAIL fill_alloc_tag got=%0d exp=%0d", alloc_tag, k + 1); end
      step();
    end
    in_vj = 32'h99;
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL fill_in_ready got=%0b exp=0", in_ready); end
    total++; if (count !== 3'd4) begin bad++; $display("[TB] FAIL fill_count got=%0d exp=4", count); end
    total++; if (out_tag !== 4'd1) begin bad++; $display("[TB] FAIL fill_out_tag got=%0d exp=1", out_tag); end
    step();
    in_valid = 1'b0;
    #1;
    total++; if (count !== 3'd4) begin bad++; $display("[TB] FAIL fill_fifth_ignored got=%0d exp=4", count); end
    total++; if (out_vj !== 32'h10) begin bad++; $display("[TB] FAIL fill_out_vj got=%0h exp=10", out_vj); end
    total++; if (out_vk !== 32'h20) begin bad++; $display("[TB] FAIL fill_out_vk got=%0h exp=20", out_vk); end
  endtask

  task automatic test_wakeup();
    do_reset();
    issue(2'd1, 32'h0, 4'd7, 32'h11, 4'd0);
    #1;
    total++; if (alloc_tag !== 4'd1) begin bad++; $display("[TB] FAIL wake_alloc_a got=%0d exp=1", alloc_tag); end
    step();
    issue(2'd2, 32'h22, 4'd0, 32'h33, 4'd0);
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL wake_a_not_ready got=%0b exp=0", out_valid); end
    step();
    in_valid = 1'b0;
    #1;
    total++; if (out_tag !== 4'd2) begin bad++; $display("[TB] FAIL wake_b_first got=%0d exp=2", out_tag); end
    total++; if (out_vj !== 32'h22) begin bad++; $display("[TB] FAIL wake_b_vj got=%0h exp=22", out_vj); end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    cdb_valid = 1'b1;
    cdb_tag   = 4'd7;
    cdb_data  = 32'hDEAD;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL wake_same_cycle got=%0b exp=0", out_valid); end
    total++; if (count !== 3'd1) begin bad++; $display("[TB] FAIL wake_count got=%0d exp=1", count); end
    step();
    cdb_valid = 1'b0;
    #1;
    total++; if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL wake_a_ready got=%0b exp=1", out_valid); end
    total++; if (out_tag !== 4'd1) begin bad++; $display("[TB] FAIL wake_a_tag got=%0d exp=1", out_tag); end
    total++; if (out_vj !== 32'hDEAD) begin bad++; $display("[TB] FAIL wake_a_vj got=%0h exp=dead", out_vj); end
    total++; if (out_op !== 2'd1) begin bad++; $display("[TB] FAIL wake_a_op got=%0d exp=1", out_op); end
  endtask

  task automatic test_bypass();
    do_reset();
    issue(2'd3, 32'h1, 4'd5, 32'h2, 4'd5);
    cdb_valid = 1'b1;
    cdb_tag   = 4'd5;
    cdb_data  = 32'h1234;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL bypass_same_cycle got=%0b exp=0", out_valid); end
    step();
    in_valid  = 1'b0;
    cdb_valid = 1'b0;
    #1;
    total++; if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL bypass_next_cycle got=%0b exp=1", out_valid); end
    total++; if (out_vj !== 32'h1234) begin bad++; $display("[TB] FAIL bypass_vj got=%0h exp=1234", out_vj); end
    total++; if (out_vk !== 32'h1234) begin bad++; $display("[TB] FAIL bypass_vk got=%0h exp=1234", out_vk); end
  endtask

  task automatic test_back_to_back();
    int exp_tag [4] = '{1, 3, 4, 2};
    do_reset();
    for (int k = 0; k < 4; k++) begin
      issue(2'd0, 32'h100 * (k + 1), (k == 1) ? 4'd0 : 4'd9, 32'h0, 4'd0);
      step();
    end
    issue(2'd1, 32'h500, 4'd0, 32'h0, 4'd0);
    out_ready = 1'b1;
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL reuse_full_in_ready got=%0b exp=0", in_ready); end
    total++; if (out_tag !== 4'd2) begin bad++; $display("[TB] FAIL reuse_dispatch_tag got=%0d exp=2", out_tag); end
    step();
    out_ready = 1'b0;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL reuse_in_ready got=%0b exp=1", in_ready); end
    total++; if (alloc_tag !== 4'd2) begin bad++; $display("[TB] FAIL reuse_alloc_tag got=%0d exp=2", alloc_tag); end
    total++; if (count !== 3'd3) begin bad++; $display("[TB] FAIL reuse_count_3 got=%0d exp=3", count); end
    step();
    in_valid  = 1'b0;
    cdb_valid = 1'b1;
    cdb_tag   = 4'd9;
    cdb_data  = 32'h900;
    #1;
    total++; if (count !== 3'd4) begin bad++; $display("[TB] FAIL reuse_count_4 got=%0d exp=4", count); end
    step();
    cdb_valid = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      total++; if (out_tag !== 4'(exp_tag[k])) begin bad++; $display("[TB] FAIL reuse_order_%0d got=%0d exp=%0d", k, out_tag, exp_tag[k]); end
      step();
    end
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reuse_drained got=%0b exp=0", out_valid); end
    total++; if (count !== 3'd0) begin bad++; $display("[TB] FAIL reuse_count_0 got=%0d exp=0", count); end
  endtask

  task automatic test_age_order();
    do_reset();
    issue(2'd0, 32'hA1, 4'd0, 32'h0, 4'd0);
    step();
    issue(2'd0, 32'hA2, 4'd0, 32'h0, 4'd0);
    step();
    issue(2'd0, 32'h0, 4'd8, 32'hC3, 4'd0);
    step();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #1;
    total++; if (out_tag !== 4'd1) begin bad++; $display("[TB] FAIL age_first got=%0d exp=1", out_tag); end
    step();
    #1;
    total++; if (out_tag !== 4'd2) begin bad++; $display("[TB] FAIL age_second got=%0d exp=2", out_tag); end
    step();
    out_ready = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL age_waiting got=%0b exp=0", out_valid); end
    issue(2'd0, 32'h0, 4'd8, 32'hC1, 4'd0);
    #1;
    total++; if (alloc_tag !== 4'd1) begin bad++; $display("[TB] FAIL age_realloc_tag got=%0d exp=1", alloc_tag); end
    step();
    in_valid  = 1'b0;
    cdb_valid = 1'b1;
    cdb_tag   = 4'd8;
    cdb_data  = 32'h88;
    step();
    cdb_valid = 1'b0;
    out_ready = 1'b1;
    #1;
    total++; if (out_tag !== 4'd3) begin bad++; $display("[TB] FAIL age_older_first got=%0d exp=3", out_tag); end
    total++; if (out_vj !== 32'h88) begin bad++; $display("[TB] FAIL age_older_vj got=%0h exp=88", out_vj); end
    step();
    #1;
    total++; if (out_tag !== 4'd1) begin bad++; $display("[TB] FAIL age_younger_next got=%0d exp=1", out_tag); end
    step();
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL age_drained got=%0b exp=0", out_valid); end
  endtask

  task automatic test_flush();
    do_reset();
    issue(2'd2, 32'h55, 4'd0, 32'h66, 4'd0);
    cdb_valid = 1'b1;
    cdb_tag   = 4'd0;
    cdb_data  = 32'hBAD;
    step();
    in_valid = 1'b0;
    #1;
    total++; if (out_vj !== 32'h55) begin bad++; $display("[TB] FAIL tag0_bypass got=%0h exp=55", out_vj); end
    step();
    cdb_valid = 1'b0;
    #1;
    total++; if (out_vj !== 32'h55) begin bad++; $display("[TB] FAIL tag0_wakeup_vj got=%0h exp=55", out_vj); end
    total++; if (out_vk !== 32'h66) begin bad++; $display("[TB] FAIL tag0_wakeup_vk got=%0h exp=66", out_vk); end
    issue(2'd0, 32'h77, 4'd0, 32'h0, 4'd0);
    step();
    issue(2'd0, 32'h78, 4'd0, 32'h0, 4'd0);
    step();
    in_valid = 1'b0;
    #1;
    total++; if (count !== 3'd3) begin bad++; $display("[TB] FAIL flush_pre_count got=%0d exp=3", count); end
    flush     = 1'b1;
    out_ready = 1'b1;
    issue(2'd0, 32'h79, 4'd0, 32'h0, 4'd0);
    #1;
    total++; if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL flush_handshake got=%0b exp=1", out_valid); end
    step();
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #1;
    total++; if (count !== 3'd0) begin bad++; $display("[TB] FAIL flush_count got=%0d exp=0", count); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL flush_out_valid got=%0b exp=0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL flush_in_ready got=%0b exp=1", in_ready); end
    step();
    #1;
    total++; if (count !== 3'd0) begin bad++; $display("[TB] FAIL flush_stays_empty got=%0d exp=0", count); end
  endtask

  initial begin
    idle_inputs();
    nRST = 1'b0;
    test_reset();
    test_fill();
    test_wakeup();
    test_bypass();
    test_back_to_back();
    test_age_order();
    test_flush();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
